// File: rtl/aes_subbytes_seq_if.sv
// ---------------------------------------------------------------------------
// aes_subbytes_seq_if
// Bundles the three handshake groups of the byte-serial SubBytes sequencer:
//   input side   : in_valid / in_ready / in_state[127:0] / in_inv
//   S-box side   : sbox_valid / sbox_in[7:0] / sbox_inv  -> shared S-box
//                  sbox_out[7:0]                        <- shared S-box
//   output side  : out_valid / out_ready / out_state[127:0]
//   status       : busy
// Modports:
//   slave  - the sequencer itself
//   master - the surrounding system (round control, S-box, consumer)
// ---------------------------------------------------------------------------
interface aes_subbytes_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_inv;
    logic         sbox_valid;
    logic [7:0]   sbox_in;
    logic         sbox_inv;
    logic [7:0]   sbox_out;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    modport slave (
        input  in_valid, in_state, in_inv, sbox_out, out_ready,
        output in_ready, sbox_valid, sbox_in, sbox_inv, out_valid, out_state, busy
    );

    modport master (
        output in_valid, in_state, in_inv, sbox_out, out_ready,
        input  in_ready, sbox_valid, sbox_in, sbox_inv, out_valid, out_state, busy
    );
endinterface

// File: rtl/aes_subbytes_seq.sv
// ---------------------------------------------------------------------------
// aes_subbytes_seq
// Byte-serial SubBytes sequencer for the 128-bit AES state. A state word is
// accepted over a valid/ready handshake, its 16 bytes (byte k = bits
// [8k+7:8k]) are issued one per cycle to a single shared external S-box,
// the returned bytes are collected back into place and the full substituted
// state is presented over a valid/ready handshake.
// Parameters:
//   SBOX_LAT - S-box latency in cycles from request to sbox_out (0, 1 or 2)
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - aes_subbytes_seq_if.slave (input, S-box and output handshakes,
//          busy status)
// ---------------------------------------------------------------------------
module aes_subbytes_seq #(
    parameter int SBOX_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    aes_subbytes_seq_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Last counter value of the DRAIN phase; the phase is skipped when the
    // S-box is combinational, so the clamp only keeps the constant legal.
    localparam int         DRAIN_N    = (SBOX_LAT > 0) ? (SBOX_LAT - 1) : 0;
    localparam logic [3:0] DRAIN_LAST = DRAIN_N[3:0];

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] cap_state_q;
    logic         cap_inv_q;
    logic [127:0] res_q;

    logic         accept;
    logic         issue_vld;
    logic         tag_vld;
    logic [3:0]   tag_idx;

    logic         in_ready_c;
    logic         sbox_valid_c;
    logic [7:0]   sbox_in_c;
    logic         sbox_inv_c;
    logic         out_valid_c;

    assign accept    = (state_q == IDLE) && bus.in_valid;
    assign issue_vld = (state_q == ISSUE);

    // Next-state and output decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        in_ready_c   = 1'b0;
        sbox_valid_c = 1'b0;
        sbox_in_c    = 8'h00;
        sbox_inv_c   = 1'b0;
        out_valid_c  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_d = ISSUE;
                    cnt_d   = 4'd0;
                end
            end
            ISSUE: begin
                sbox_valid_c = 1'b1;
                sbox_in_c    = cap_state_q[{cnt_q, 3'b000} +: 8];
                sbox_inv_c   = cap_inv_q;
                cnt_d        = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    cnt_d   = 4'd0;
                    state_d = (SBOX_LAT == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                // Waits out the last S-box result still in flight.
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and input capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            cap_state_q <= '0;
            cap_inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                cap_state_q <= bus.in_state;
                cap_inv_q   <= bus.in_inv;
            end
        end
    end

    // Tag pipe: {valid, byte index} travels alongside each S-box request so
    // the returning byte lands in the right lane. Clearing it on reset drops
    // any results that were still in flight.
    generate
        if (SBOX_LAT == 0) begin : g_tag_comb
            assign tag_vld = issue_vld;
            assign tag_idx = cnt_q;
        end else begin : g_tag_pipe
            logic [4:0] tag_q [SBOX_LAT];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < SBOX_LAT; i++) begin
                        tag_q[i] <= 5'd0;
                    end
                end else begin
                    tag_q[0] <= {issue_vld, cnt_q};
                    for (int i = 1; i < SBOX_LAT; i++) begin
                        tag_q[i] <= tag_q[i-1];
                    end
                end
            end
            assign tag_vld = tag_q[SBOX_LAT-1][4];
            assign tag_idx = tag_q[SBOX_LAT-1][3:0];
        end
    endgenerate

    // Result assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
        end else if (tag_vld) begin
            res_q[{tag_idx, 3'b000} +: 8] <= bus.sbox_out;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.sbox_valid = sbox_valid_c;
    assign bus.sbox_in    = sbox_in_c;
    assign bus.sbox_inv   = sbox_inv_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.out_state  = res_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_aes_subbytes_seq.sv
module tb_aes_subbytes_seq;

    logic clk;
    logic rst;

    logic         in_valid;
    logic [127:0] drv_state;
    logic         drv_inv;
    logic         out_ready;
    int           sel;

    int checks;
    int failures;

    logic [7:0] sbox_t  [256];
    logic [7:0] isbox_t [256];

    aes_subbytes_seq_if bus0();
    aes_subbytes_seq_if bus1();
    aes_subbytes_seq_if bus2();

    aes_subbytes_seq #(.SBOX_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    aes_subbytes_seq #(.SBOX_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    aes_subbytes_seq #(.SBOX_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign bus0.in_valid  = in_valid && (sel == 0);
    assign bus1.in_valid  = in_valid && (sel == 1);
    assign bus2.in_valid  = in_valid && (sel == 2);
    assign bus0.in_state  = drv_state;
    assign bus1.in_state  = drv_state;
    assign bus2.in_state  = drv_state;
    assign bus0.in_inv    = drv_inv;
    assign bus1.in_inv    = drv_inv;
    assign bus2.in_inv    = drv_inv;
    assign bus0.out_ready = out_ready;
    assign bus1.out_ready = out_ready;
    assign bus2.out_ready = out_ready;

    // External S-box models with latency 0, 1 and 2
    assign bus0.sbox_out = bus0.sbox_inv ? isbox_t[bus0.sbox_in] : sbox_t[bus0.sbox_in];

    always @(posedge clk) begin
        bus1.sbox_out <= bus1.sbox_inv ? isbox_t[bus1.sbox_in] : sbox_t[bus1.sbox_in];
    end

    logic [7:0] s2_stage;
    always @(posedge clk) begin
        s2_stage      <= bus2.sbox_inv ? isbox_t[bus2.sbox_in] : sbox_t[bus2.sbox_in];
        bus2.sbox_out <= s2_stage;
    end

    // Observation mux over the selected DUT
    logic         o_in_ready, o_busy, o_sbox_valid, o_sbox_inv, o_out_valid;
    logic [7:0]   o_sbox_in;
    logic [127:0] o_out_state;

    always_comb begin
        o_in_ready   = bus1.in_ready;
        o_busy       = bus1.busy;
        o_sbox_valid = bus1.sbox_valid;
        o_sbox_in    = bus1.sbox_in;
        o_sbox_inv   = bus1.sbox_inv;
        o_out_valid  = bus1.out_valid;
        o_out_state  = bus1.out_state;
        if (sel == 0) begin
            o_in_ready   = bus0.in_ready;
            o_busy       = bus0.busy;
            o_sbox_valid = bus0.sbox_valid;
            o_sbox_in    = bus0.sbox_in;
            o_sbox_inv   = bus0.sbox_inv;
            o_out_valid  = bus0.out_valid;
            o_out_state  = bus0.out_state;
        end else if (sel == 2) begin
            o_in_ready   = bus2.in_ready;
            o_busy       = bus2.busy;
            o_sbox_valid = bus2.sbox_valid;
            o_sbox_in    = bus2.sbox_in;
            o_sbox_inv   = bus2.sbox_inv;
            o_out_valid  = bus2.out_valid;
            o_out_state  = bus2.out_state;
        end
    end

    // ---------------- reference model (GF(2^8) arithmetic) ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    task automatic build_tables();
        logic [7:0] b, r, s;
        for (int x = 0; x < 256; x++) begin
            b = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
                end
            end
            s = b ^ 8'h63;
            r = b;
            for (int n = 0; n < 4; n++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            sbox_t[x] = s;
        end
        for (int x = 0; x < 256; x++) isbox_t[sbox_t[x]] = 8'(x);
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] st, input logic inv);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) begin
            r[8*k +: 8] = inv ? isbox_t[st[8*k +: 8]] : sbox_t[st[8*k +: 8]];
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Runs one transaction on the selected DUT and records what it saw, up to
    // the first out_valid cycle. Called at #1 after a clock edge.
    task automatic do_op(input logic [127:0] st, input logic inv, input logic ordy,
                         output int lat, output logic [127:0] issued, output int n_iss,
                         output logic inv_ok, output logic busy_ok, output logic zero_ok);
        drv_state = st; drv_inv = inv; out_ready = ordy; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        drv_state = ~st;
        drv_inv = ~inv;
        lat = 1; issued = '0; n_iss = 0; inv_ok = 1'b1; busy_ok = 1'b1; zero_ok = 1'b1;
        while (!o_out_valid && lat < 60) begin
            if (o_busy !== 1'b1) busy_ok = 1'b0;
            if (o_sbox_valid === 1'b1) begin
                if (n_iss < 16) issued[8*n_iss +: 8] = o_sbox_in;
                n_iss++;
                if (o_sbox_inv !== inv) inv_ok = 1'b0;
            end else if (o_sbox_in !== 8'h00) begin
                zero_ok = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        if (o_busy !== 1'b1) busy_ok = 1'b0;
    endtask

    // ------------------------------- tests ---------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            checks++;
            if (o_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready lat%0d: got %b want 1", s, o_in_ready); end
            checks++;
            if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy lat%0d: got %b want 0", s, o_busy); end
            checks++;
            if (o_sbox_valid !== 1'b0) begin failures++; $display("FAIL reset_sbox_valid lat%0d: got %b want 0", s, o_sbox_valid); end
            checks++;
            if (o_sbox_in !== 8'h00 || o_sbox_inv !== 1'b0) begin failures++; $display("FAIL reset_sbox_bus lat%0d: got in=%h inv=%b want 00/0", s, o_sbox_in, o_sbox_inv); end
            checks++;
            if (o_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid lat%0d: got %b want 0", s, o_out_valid); end
            checks++;
            if (o_out_state !== 128'h0) begin failures++; $display("FAIL reset_out_state lat%0d: got %h want 0", s, o_out_state); end
        end
    endtask

    task automatic test_zero_fwd();
        int lat, n; logic [127:0] iss; logic iok, bok, zok;
        sel = 1; #1;
        do_op(128'h0, 1'b0, 1'b1, lat, iss, n, iok, bok, zok);
        checks++;
        if (lat !== 18) begin failures++; $display("FAIL zero_latency: got %0d want 18", lat); end
        checks++;
        if (o_out_state !== {16{8'h63}}) begin failures++; $display("FAIL zero_result: got %h want %h", o_out_state, {16{8'h63}}); end
        checks++;
        if (bok !== 1'b1) begin failures++; $display("FAIL zero_busy: got %b want 1", bok); end
        checks++;
        if (n !== 16 || zok !== 1'b1) begin failures++; $display("FAIL zero_issue_count: got %0d zero_ok=%b want 16/1", n, zok); end
        @(posedge clk); #1;
        checks++;
        if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin failures++; $display("FAIL zero_handshake: got in_ready=%b out_valid=%b want 1/0", o_in_ready, o_out_valid); end
    endtask

    task automatic test_byte_order(input int s);
        int lat, n; logic [127:0] iss; logic iok, bok, zok;
        logic [127:0] st, expv;
        st   = 128'h0f0e0d0c0b0a09080706050403020100;
        expv = 128'h76abd7fe2b670130c56f6bf27b777c63;
        sel = s; #1;
        do_op(st, 1'b0, 1'b1, lat, iss, n, iok, bok, zok);
        checks++;
        if (iss !== st || n !== 16) begin failures++; $display("FAIL order_sbox_in lat%0d: got %h (%0d bytes) want %h", s, iss, n, st); end
        checks++;
        if (o_out_state !== expv) begin failures++; $display("FAIL order_result lat%0d: got %h want %h", s, o_out_state, expv); end
        checks++;
        if (lat !== 17 + s) begin failures++; $display("FAIL order_latency lat%0d: got %0d want %0d", s, lat, 17 + s); end
        checks++;
        if (iok !== 1'b1 || bok !== 1'b1) begin failures++; $display("FAIL order_inv_busy lat%0d: got inv_ok=%b busy_ok=%b want 1/1", s, iok, bok); end
        @(posedge clk); #1;
    endtask

    task automatic test_inverse();
        int lat, n; logic [127:0] iss; logic iok, bok, zok;
        sel = 1; #1;
        do_op(128'h76abd7fe2b670130c56f6bf27b777c63, 1'b1, 1'b1, lat, iss, n, iok, bok, zok);
        checks++;
        if (iok !== 1'b1 || n !== 16) begin failures++; $display("FAIL inv_sbox_inv: got inv_ok=%b n=%0d want 1/16", iok, n); end
        checks++;
        if (o_out_state !== 128'h0f0e0d0c0b0a09080706050403020100) begin failures++; $display("FAIL inv_result: got %h want 0f0e0d0c0b0a09080706050403020100", o_out_state); end
        @(posedge clk); #1;
    endtask

    task automatic test_random(input int s, input int reps);
        int lat, n; logic [127:0] iss; logic iok, bok, zok;
        logic [127:0] st; logic inv;
        sel = s; #1;
        for (int r = 0; r < reps; r++) begin
            st = rand128(); inv = 1'($urandom_range(0, 1));
            do_op(st, inv, 1'b1, lat, iss, n, iok, bok, zok);
            checks++;
            if (o_out_state !== ref_sub(st, inv)) begin failures++; $display("FAIL random_result lat%0d: got %h want %h", s, o_out_state, ref_sub(st, inv)); end
            checks++;
            if (lat !== 17 + s || iss !== st || iok !== 1'b1 || zok !== 1'b1) begin failures++; $display("FAIL random_issue lat%0d: got lat=%0d issued=%h inv_ok=%b zero_ok=%b want %0d/%h/1/1", s, lat, iss, iok, zok, 17 + s, st); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int lat, n; logic [127:0] iss; logic iok, bok, zok;
        logic [127:0] st, res0;
        sel = 1; #1;
        st = rand128();
        do_op(st, 1'b0, 1'b0, lat, iss, n, iok, bok, zok);
        res0 = o_out_state;
        checks++;
        if (res0 !== ref_sub(st, 1'b0) || lat !== 18) begin failures++; $display("FAIL bp_result: got %h lat=%0d want %h lat=18", res0, lat, ref_sub(st, 1'b0)); end
        for (int c = 0; c < 10; c++) begin
            drv_state = rand128(); drv_inv = 1'b1; in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (o_out_valid !== 1'b1 || o_out_state !== res0 || o_in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle %0d: got out_valid=%b in_ready=%b state=%h want 1/0/%h", c, o_out_valid, o_in_ready, o_out_state, res0);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin failures++; $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1/0", o_in_ready, o_out_valid); end
        checks++;
        if (o_out_state !== res0) begin failures++; $display("FAIL bp_result_held: got %h want %h", o_out_state, res0); end
        @(posedge clk); #1;
        checks++;
        if (o_busy !== 1'b0) begin failures++; $display("FAIL bp_no_accept: got busy=%b want 0", o_busy); end
    endtask

    task automatic test_reset_mid(input int s);
        int lat, n; logic [127:0] iss; logic iok, bok, zok;
        logic [127:0] st, st2;
        sel = s; #1;
        st = rand128();
        drv_state = st; drv_inv = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if (o_sbox_valid !== 1'b1 || o_sbox_in !== st[63:56]) begin failures++; $display("FAIL midrst_k7 lat%0d: got valid=%b in=%h want 1/%h", s, o_sbox_valid, o_sbox_in, st[63:56]); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (o_in_ready !== 1'b1 || o_busy !== 1'b0 || o_sbox_valid !== 1'b0 || o_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_state lat%0d: got in_ready=%b busy=%b sbox_valid=%b out_valid=%b want 1/0/0/0", s, o_in_ready, o_busy, o_sbox_valid, o_out_valid);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (o_out_state !== 128'h0 || o_out_valid !== 1'b0) begin failures++; $display("FAIL midrst_inflight lat%0d cycle %0d: got %h valid=%b want 0/0", s, c, o_out_state, o_out_valid); end
        end
        st2 = rand128();
        do_op(st2, 1'b1, 1'b1, lat, iss, n, iok, bok, zok);
        checks++;
        if (o_out_state !== ref_sub(st2, 1'b1) || lat !== 17 + s) begin failures++; $display("FAIL midrst_fresh lat%0d: got %h lat=%0d want %h lat=%0d", s, o_out_state, lat, ref_sub(st2, 1'b1), 17 + s); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_q[$];
        logic [127:0] expv, st;
        int acc_cyc[$];
        int cyc, n_out;
        logic accepting;
        sel = 1; #1;
        out_ready = 1'b1; drv_inv = 1'b0;
        st = rand128(); drv_state = st; in_valid = 1'b1;
        cyc = 0; n_out = 0;
        while (n_out < 3 && cyc < 200) begin
            accepting = 1'b0;
            if (o_out_valid === 1'b1) begin
                expv = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                n_out++;
                checks++;
                if (o_out_state !== expv) begin failures++; $display("FAIL b2b_result %0d: got %h want %h", n_out, o_out_state, expv); end
            end
            if (in_valid && o_in_ready === 1'b1) begin
                acc_cyc.push_back(cyc);
                exp_q.push_back(ref_sub(st, 1'b0));
                accepting = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
            if (accepting) begin
                st = rand128(); drv_state = st;
                if (acc_cyc.size() == 3) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (n_out !== 3 || acc_cyc.size() != 3) begin
            failures++;
            $display("FAIL b2b_count: got %0d results %0d accepts want 3/3", n_out, acc_cyc.size());
        end else begin
            checks++;
            if (acc_cyc[1] - acc_cyc[0] !== 19 || acc_cyc[2] - acc_cyc[1] !== 19) begin
                failures++;
                $display("FAIL b2b_spacing: got %0d,%0d want 19,19", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; in_valid = 1'b0; drv_state = '0; drv_inv = 1'b0; out_ready = 1'b0; sel = 1;
        build_tables();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_zero_fwd();
        test_byte_order(1);
        test_inverse();
        test_random(1, 4);
        test_backpressure();
        test_reset_mid(1);
        test_reset_mid(2);
        test_byte_order(0);
        test_byte_order(2);
        test_random(0, 3);
        test_random(2, 3);
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
